// File: rtl/pulse_period_reporter_pkg.sv
// Shared types and constants for the pulse period reporter:
// reporter states, ASCII message/command bytes and a hex digit helper.
package pulse_period_reporter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    SEND,
    WAIT
  } state_e;

  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_P     = 8'h70;
  localparam logic [7:0] ASCII_G     = 8'h67;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) res = 8'h30 + {4'h0, nib};
    else res = 8'h37 + {4'h0, nib};
    return res;
  endfunction

endpackage

// File: rtl/pulse_period_channel.sv
// One measured input: synchronizer, rising-edge detect, saturating
// period counter, holding register and pending/armed flags.
module pulse_period_channel
  import pulse_period_reporter_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_i,
  input  logic             clr_i,
  output logic             pend_o,
  output logic [CNT_W-1:0] hold_o
);

  logic             meta_q;
  logic             sync_q;
  logic             prev_q;
  logic             armed_q;
  logic             pend_q;
  logic             pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;
  logic [CNT_W:0]   inc_w;
  logic             edge_w;
  logic             latch_w;

  assign edge_w  = sync_q & ~prev_q;
  assign latch_w = edge_w & armed_q;
  assign inc_w   = {1'b0, cnt_q} + (CNT_W+1)'(1);

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    pend_d = pend_q;
    if (edge_w) cnt_d = '0;
    else if (!inc_w[CNT_W]) cnt_d = inc_w[CNT_W-1:0];
    if (latch_w) hold_d = inc_w[CNT_W] ? '1 : inc_w[CNT_W-1:0];
    // a fresh latch outranks the reporter's clear in the same cycle
    if (latch_w) pend_d = 1'b1;
    else if (clr_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (edge_w) armed_q <= 1'b1;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign pend_o = pend_q;
  assign hold_o = hold_q;

endmodule

// File: rtl/pulse_period_reporter.sv
// Measures the period of NUM_CH pulse inputs and reports each new
// period as "C<n>:<hex>\r\n" over a byte-wide serial transmitter.
module pulse_period_reporter
  import pulse_period_reporter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig_in,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data
);

  localparam int ND = CNT_W / 4;
  localparam int NB = ND + 5;
  localparam int MW = 8 * NB;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            pend_w;
  logic [NUM_CH-1:0]            clr_w;
  logic [NUM_CH-1:0][CNT_W-1:0] hold_w;
  logic [CNT_W-1:0]             hold_sel_w;

  state_e        state_q;
  logic [IW-1:0] sel_q;
  logic [IW-1:0] rr_q;
  logic [MW-1:0] msg_q;
  logic [MW-1:0] msg_d;
  logic [3:0]    left_q;
  logic          running_q;

  logic          found_w;
  logic [IW-1:0] pick_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_period_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .sig_i (sig_in[g]),
      .clr_i (clr_w[g]),
      .pend_o(pend_w[g]),
      .hold_o(hold_w[g])
    );
  end

  // round-robin search, starting just after the last channel printed
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j       = 0;
    jj      = '0;
    found_w = 1'b0;
    pick_w  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      jj = IW'(j);
      if (!found_w && pend_w[jj]) begin
        found_w = 1'b1;
        pick_w  = jj;
      end
    end
  end

  always_comb begin
    clr_w = '0;
    if (state_q == SNAP) clr_w[sel_q] = 1'b1;
  end

  assign hold_sel_w = hold_w[sel_q];

  always_comb begin
    msg_d = '0;
    msg_d[MW-1 -: 8]  = ASCII_C;
    msg_d[MW-9 -: 8]  = ASCII_ZERO + 8'(sel_q);
    msg_d[MW-17 -: 8] = ASCII_COLON;
    for (int k = 0; k < ND; k++) begin
      msg_d[MW-25-8*k -: 8] = nib2hex(hold_sel_w[CNT_W-1-4*k -: 4]);
    end
    msg_d[15:8] = ASCII_CR;
    msg_d[7:0]  = ASCII_LF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rr_q      <= IW'(NUM_CH - 1);
      msg_q     <= '0;
      left_q    <= '0;
      running_q <= 1'b1;
    end else begin
      if (new_rx_data) begin
        if (rx_data == ASCII_P) running_q <= 1'b0;
        else if (rx_data == ASCII_G) running_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (running_q && found_w) begin
            sel_q   <= pick_w;
            state_q <= SNAP;
          end
        end
        SNAP: begin
          msg_q   <= msg_d;
          left_q  <= 4'(NB);
          rr_q    <= sel_q;
          state_q <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            msg_q   <= {msg_q[MW-9:0], 8'h00};
            left_q  <= left_q - 4'd1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (left_q == 4'd0) state_q <= IDLE;
          else if (!tx_busy) state_q <= SEND;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // the strobe is gated by tx_busy so it can never overlap a busy cycle
  assign tx_data     = msg_q[MW-1 -: 8];
  assign new_tx_data = (state_q == SEND) && !tx_busy;

endmodule

// File: tb/tb_pulse_period_reporter.sv
// Scoreboard bench for pulse_period_reporter: directed scenarios plus
// randomized edge bursts checked against a message-level model.
`timescale 1ns/1ps
module tb_pulse_period_reporter;

  localparam int MAXP = 2**24 - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig;
  logic [7:0] tx_data;
  logic       new_tx;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       new_rx;
  logic [3:0] sig8;
  logic [7:0] tx_data8;
  logic       new_tx8;
  logic       busy_e;
  logic       busy_hold;

  always #5 clk = ~clk;
  assign tx_busy = busy_e | busy_hold;

  pulse_period_reporter #(.NUM_CH(4), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .sig_in(sig),
    .tx_data(tx_data), .new_tx_data(new_tx), .tx_busy(tx_busy),
    .rx_data(rx_data), .new_rx_data(new_rx)
  );

  pulse_period_reporter #(.NUM_CH(4), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .sig_in(sig8),
    .tx_data(tx_data8), .new_tx_data(new_tx8), .tx_busy(1'b0),
    .rx_data(8'h00), .new_rx_data(1'b0)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int str_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp8_q[$];
  logic [7:0] eb;
  logic [7:0] eb8;
  logic prev_str = 1'b0;
  logic prev_str8 = 1'b0;
  int busy_len = 10;

  // reference model: per-channel edge history, pending values, printer order
  int last_e[4];
  bit armed[4];
  bit pend[4];
  int pval[4];
  int last_pr;
  bit running;

  // monitor: pops the scoreboard whenever a DUT presents a byte
  always @(negedge clk) begin
    if (new_tx) begin
      strobes++;
      str_cyc.push_back(cyc);
      checks++;
      if (tx_busy || prev_str) begin
        errors++;
        $display("FAIL strobe_rule busy=%0b prev=%0b required 0/0", tx_busy, prev_str);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_byte got %02h required no byte", tx_data);
      end else begin
        eb = exp_q.pop_front();
        if (tx_data !== eb) begin
          errors++;
          $display("FAIL tx_byte got %02h required %02h", tx_data, eb);
        end
      end
    end
    prev_str = new_tx;
    if (new_tx8) begin
      checks++;
      if (prev_str8) begin
        errors++;
        $display("FAIL strobe8_rule consecutive strobes got 1 required 0");
      end
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL tx8_byte got %02h required no byte", tx_data8);
      end else begin
        eb8 = exp8_q.pop_front();
        if (tx_data8 !== eb8) begin
          errors++;
          $display("FAIL tx8_byte got %02h required %02h", tx_data8, eb8);
        end
      end
    end
    prev_str8 = new_tx8;
  end

  // transmitter emulation: busy from the cycle after a strobe
  initial begin
    busy_e = 1'b0;
    forever begin
      @(negedge clk);
      if (new_tx) begin
        @(posedge clk);
        #1 busy_e = 1'b1;
        repeat (busy_len - 1) @(posedge clk);
        #1 busy_e = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycles=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  function automatic void push_msg(int c, int v, int nd, bit to8);
    string s;
    string hx;
    int n;
    hx = "0123456789ABCDEF";
    s = $sformatf("C%0d:", c);
    for (int k = nd - 1; k >= 0; k--) begin
      n = (v >> (4 * k)) & 15;
      s = {s, hx.substr(n, n)};
    end
    for (int i = 0; i < s.len(); i++) begin
      if (to8) exp8_q.push_back(s[i]);
      else exp_q.push_back(s[i]);
    end
    if (to8) begin
      exp8_q.push_back(8'h0D);
      exp8_q.push_back(8'h0A);
    end else begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic void drain();
    int base;
    int c;
    base = last_pr;
    for (int i = 1; i <= 4; i++) begin
      c = (base + i) % 4;
      if (pend[c]) begin
        push_msg(c, pval[c], 6, 1'b0);
        pend[c] = 1'b0;
        last_pr = c;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      armed[c] = 1'b0;
      pend[c] = 1'b0;
      pval[c] = 0;
      last_e[c] = 0;
    end
    last_pr = 3;
    running = 1'b1;
    exp_q.delete();
  endfunction

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edges(input logic [3:0] m);
    int p;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        if (armed[c]) begin
          p = cyc - last_e[c];
          if (p > MAXP) p = MAXP;
          pend[c] = 1'b1;
          pval[c] = p;
        end else begin
          armed[c] = 1'b1;
        end
        last_e[c] = cyc;
      end
    end
    if (running) drain();
    sig = sig | m;
    gap(3);
    sig = sig & ~m;
  endtask

  task automatic edges8(input logic [3:0] m);
    sig8 = sig8 | m;
    gap(3);
    sig8 = sig8 & ~m;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_data = b;
    new_rx = 1'b1;
    @(posedge clk);
    #1 new_rx = 1'b0;
  endtask

  task automatic wait_strobes(input int target);
    int n;
    n = 0;
    while (strobes < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("strobe_wait", strobes >= target, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size() + exp8_q.size(), 0);
    exp_q.delete();
    exp8_q.delete();
    gap(20);
  endtask

  initial begin
    int rec;
    int n0;
    int h;
    logic [3:0] m;
    rst = 1'b1;
    sig = '0;
    sig8 = '0;
    rx_data = 8'h00;
    new_rx = 1'b0;
    busy_hold = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_data", tx_data, 0);
    chk("reset_strobe", new_tx, 0);
    chk("reset_tx_data8", tx_data8, 0);
    rst = 1'b0;
    gap(5);

    // period of 1000 cycles, with first-strobe latency
    edges(4'b0001);
    gap(997);
    rec = strobes;
    n0 = cyc;
    edges(4'b0001);
    wait_strobes(rec + 1);
    chk("first_strobe_latency", str_cyc[rec] - n0, 5);
    wait_drain();
    chk("msg1_strobes", strobes - rec, 11);

    // ch1 and ch3 latch in the same cycle
    edges(4'b1010);
    gap(197);
    edges(4'b1010);
    wait_drain();

    // narrow counter saturates
    edges8(4'b0001);
    gap(297);
    push_msg(0, 255, 2, 1'b1);
    edges8(4'b0001);
    gap(97);
    push_msg(0, 100, 2, 1'b1);
    edges8(4'b0001);
    wait_drain();

    // pause mid-message, newest pending period wins on resume
    rec = strobes;
    edges(4'b0001);
    wait_strobes(rec + 2);
    rx(8'h70);
    running = 1'b0;
    rx(8'h41);
    gap(100);
    edges(4'b0001);
    gap(297);
    edges(4'b0001);
    gap(600);
    chk("paused_left", exp_q.size(), 0);
    chk("paused_strobes", strobes - rec, 11);
    rx(8'h67);
    running = 1'b1;
    drain();
    wait_drain();

    // transmitter stalls for 500 cycles mid-message
    rec = strobes;
    edges(4'b0001);
    wait_strobes(rec + 3);
    busy_hold = 1'b1;
    h = strobes;
    gap(500);
    chk("stall_strobes", strobes - h, 0);
    busy_hold = 1'b0;
    wait_drain();
    chk("stall_msg_strobes", strobes - rec, 11);

    // reset during the 4th byte
    rec = strobes;
    edges(4'b0001);
    wait_strobes(rec + 4);
    rst = 1'b1;
    #1;
    chk("rst_strobe", new_tx, 0);
    chk("rst_tx_data", tx_data, 0);
    model_reset();
    gap(2);
    rst = 1'b0;
    gap(60);
    chk("rst_abort_strobes", strobes - rec, 4);
    edges(4'b0001);
    gap(397);
    edges(4'b0001);
    wait_drain();

    // randomized bursts across channels
    for (int it = 0; it < 12; it++) begin
      m = 4'($urandom_range(1, 15));
      busy_len = $urandom_range(2, 12);
      gap($urandom_range(6, 1500));
      edges(m);
      wait_drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
